// File: rtl/lcd_line_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_pkg
//  Purpose  : Shared constants for the character-LCD line writer: HD44780
//             command bytes, the blank character, the title text table and
//             the write-engine state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package lcd_pkg;

  // HD44780 commands (8-bit interface, 2 lines, 5x8 font)
  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY      = 8'h06;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] LINE1      = 8'h80;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Width of the position / item index (covers LINE_LEN up to 40 plus the
  // leading cursor command).
  localparam int POS_W = 6;

  // Title table. Every entry is padded with spaces to TITLE_LEN so a single
  // packed width holds them all; character 0 is the most significant byte.
  localparam int TITLE_CNT = 4;
  localparam int TITLE_LEN = 12;
  localparam logic [8*TITLE_LEN-1:0] TITLES [TITLE_CNT] = '{
    "MODE1: WATCH",
    "MODE2: ALARM",
    "MODE3: STOP ",
    "MODE4: SET  "
  };

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_CLR_WAIT = 3'd2,
    ST_DRAW     = 3'd3,
    ST_IDLE     = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_line_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_line_writer_if
//  Purpose  : Bundle between the mode controller and the LCD pins.
//  Signals  : mode     - selected title index        (master -> slave)
//             refresh  - one-cycle redraw request    (master -> slave)
//             busy     - engine initialising/drawing (slave  -> master)
//             lcd_e    - LCD enable strobe           (slave  -> pins)
//             lcd_rs   - 0 = command, 1 = data       (slave  -> pins)
//             lcd_rw   - always 0, write only        (slave  -> pins)
//             lcd_data - LCD data bus                (slave  -> pins)
//  Revision : 1.0  initial release
// ============================================================================
interface lcd_line_writer_if #(
  parameter int MODE_W = 2
);
  logic [MODE_W-1:0] mode;
  logic              refresh;
  logic              busy;
  logic              lcd_e;
  logic              lcd_rs;
  logic              lcd_rw;
  logic [7:0]        lcd_data;

  modport master (
    output mode, refresh,
    input  busy, lcd_e, lcd_rs, lcd_rw, lcd_data
  );

  modport slave (
    input  mode, refresh,
    output busy, lcd_e, lcd_rs, lcd_rw, lcd_data
  );
endinterface
`default_nettype wire

// File: rtl/lcd_line_writer_title_rom.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_title_rom
//  Purpose  : Combinational map of (mode, character position) to an ASCII
//             byte. Positions past the title end and unknown modes give a
//             space.
//  Ports    : mode_i [MODE_W] - title index
//             pos_i  [POS_W]  - character position on the line
//             char_o [8]      - ASCII character
//  Revision : 1.0  initial release
// ============================================================================
module lcd_title_rom
  import lcd_pkg::*;
#(
  parameter int MODE_W = 2,
  parameter int POS_W  = 6
) (
  input  logic [MODE_W-1:0] mode_i,
  input  logic [POS_W-1:0]  pos_i,
  output logic [7:0]        char_o
);

  always_comb begin
    char_o = CHAR_SPACE;
    for (int m = 0; m < TITLE_CNT; m++) begin
      for (int p = 0; p < TITLE_LEN; p++) begin
        if ((32'(mode_i) == 32'(m)) && (32'(pos_i) == 32'(p))) begin
          char_o = TITLES[m][8*(TITLE_LEN-1-p) +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_line_writer.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_line_writer
//  Purpose  : Character-LCD write engine. After reset it waits for LCD
//             power-up, runs the HD44780 8-bit init, then writes the
//             selected mode title to line 1. Redraws on mode change or
//             refresh; events arriving while busy are remembered and served
//             with one extra redraw once the current sequence ends.
//  Ports    : clk   - system clock
//             rst_n - asynchronous active-low reset
//             bus   - lcd_line_writer_if.slave (mode, refresh, busy, LCD pins)
//  Revision : 1.0  initial release
// ============================================================================
module lcd_line_writer
  import lcd_pkg::*;
#(
  parameter int NUM_MODES = 4,
  parameter int LINE_LEN  = 16,
  parameter int WR_CYC    = 8,
  parameter int CLR_CYC   = 2000,
  parameter int PWR_CYC   = 20000
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_line_writer_if.slave   bus
);

  localparam int MODE_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int WAIT_MAX = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int PH_W     = $clog2(WR_CYC);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [POS_W-1:0]    idx_q, idx_d;      // item within INIT or DRAW
  logic [MODE_W-1:0]   cur_mode_q, cur_mode_d;
  logic [MODE_W-1:0]   mode_prev_q;
  logic                pending_q, pending_d;
  logic                rs_hold_q;
  logic [7:0]          data_hold_q;

  logic                item_rs;
  logic [7:0]          item_data;
  logic [7:0]          rom_char;
  logic [POS_W-1:0]    rom_pos;
  logic                active;
  logic                ph_last;
  logic                start_draw;
  logic                evt;

  // DRAW item 0 is the cursor command, so text position is idx-1.
  assign rom_pos = idx_q - POS_W'(1);

  lcd_title_rom #(
    .MODE_W (MODE_W),
    .POS_W  (POS_W)
  ) u_rom (
    .mode_i (cur_mode_q),
    .pos_i  (rom_pos),
    .char_o (rom_char)
  );

  assign active  = (state_q == ST_INIT) || (state_q == ST_DRAW);
  assign ph_last = (phase_q == PH_W'(WR_CYC - 1));

  // Mode edges are ignored during PWR_WAIT: mode_prev_q comes out of reset
  // unrelated to the live input, and the first draw latches the newest mode
  // anyway, so only a refresh there needs remembering.
  assign evt = bus.refresh ||
               ((state_q != ST_PWR_WAIT) && (bus.mode != mode_prev_q));

  // Byte for the transaction currently in progress.
  always_comb begin
    item_rs   = 1'b0;
    item_data = 8'h00;
    case (state_q)
      ST_INIT: begin
        case (idx_q[1:0])
          2'd0:    item_data = FUNC_SET;
          2'd1:    item_data = DISP_ON;
          2'd2:    item_data = ENTRY;
          default: item_data = CLEAR;
        endcase
      end
      ST_DRAW: begin
        if (idx_q == '0) begin
          item_data = LINE1;
        end else begin
          item_rs   = 1'b1;
          item_data = rom_char;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    cur_mode_d = cur_mode_q;
    pending_d  = pending_q;
    start_draw = 1'b0;

    case (state_q)
      ST_PWR_WAIT: begin
        if (wait_q == WAIT_W'(PWR_CYC - 1)) begin
          state_d = ST_INIT;
          phase_d = '0;
          idx_d   = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_INIT: begin
        if (ph_last) begin
          phase_d = '0;
          if (idx_q == POS_W'(3)) begin
            state_d = ST_CLR_WAIT;
            wait_d  = '0;
          end else begin
            idx_d = idx_q + POS_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_CLR_WAIT: begin
        if (wait_q == WAIT_W'(CLR_CYC - 1)) begin
          start_draw = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DRAW: begin
        if (ph_last) begin
          phase_d = '0;
          if (idx_q == POS_W'(LINE_LEN)) begin
            // A queued request chains straight into a new draw.
            if (pending_q) begin
              start_draw = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + POS_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.refresh || (bus.mode != cur_mode_q)) begin
          start_draw = 1'b1;
        end
      end
      default: begin
        state_d = ST_PWR_WAIT;
        wait_d  = '0;
      end
    endcase

    if (start_draw) begin
      state_d    = ST_DRAW;
      phase_d    = '0;
      idx_d      = '0;
      cur_mode_d = bus.mode;
      pending_d  = 1'b0;
    end else if (evt && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWR_WAIT;
      wait_q      <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      cur_mode_q  <= '0;
      mode_prev_q <= '0;
      pending_q   <= 1'b0;
      rs_hold_q   <= 1'b0;
      data_hold_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      cur_mode_q  <= cur_mode_d;
      mode_prev_q <= bus.mode;
      pending_q   <= pending_d;
      if (active) begin
        rs_hold_q   <= item_rs;
        data_hold_q <= item_data;
      end
    end
  end

  // Bus follows the live item during transactions and keeps the last value
  // otherwise; everything derives from registers, so a reset clears the pins
  // without waiting for a clock edge.
  assign bus.lcd_e    = active && (phase_q != '0) && (phase_q <= PH_W'(WR_CYC / 2));
  assign bus.lcd_rs   = active ? item_rs   : rs_hold_q;
  assign bus.lcd_data = active ? item_data : data_hold_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.busy     = !((state_q == ST_IDLE) && !pending_q);

endmodule
`default_nettype wire
